// File: rtl/boton_pkg.sv
// Shared definitions for the button repeat-pulse block: state encoding,
// board timing defaults and the counter width helper.
package boton_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      REPEAT = 2'd2
   } estado_t;

   // 100 MHz board: 0.5 s before auto-repeat starts, then one pulse every 0.1 s
   localparam int HOLD_DEFAULT   = 50_000_000;
   localparam int REPEAT_DEFAULT = 10_000_000;

   // The shared counter only ever reaches max(hold, repeat) - 1
   function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
      int mayor;
      mayor = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
      return $clog2(mayor);
   endfunction

endpackage

// File: rtl/boton_pulso_repeticion_detector_flanco.sv
// Edge detector on the debounced button level. The previous sample resets
// to 1 so a button held through reset does not look like a fresh press.
module detector_flanco (
   input  logic clk,
   input  logic reset,
   input  logic senal_i,
   output logic sube_o,
   output logic baja_o
);

   logic prev_q;

   // Remember last cycle's level
   always_ff @(posedge clk) begin
      if (reset) prev_q <= 1'b1;
      else       prev_q <= senal_i;
   end

   assign sube_o = senal_i & ~prev_q;
   assign baja_o = ~senal_i & prev_q;

endmodule

// File: rtl/boton_pulso_repeticion.sv
// Turns the debounced button level into command pulses: one on press,
// then auto-repeat after a hold delay, plus held flag and release pulse.
//
// state  | meaning
// IDLE   | button released, waiting for a press edge
// WAIT   | pressed, counting the hold delay (saturates if repeat disabled)
// REPEAT | auto-repeat active, pulse every REPEAT_CYCLES
module boton_pulso_repeticion
   import boton_pkg::*;
#(
   parameter int HOLD_CYCLES   = HOLD_DEFAULT,
   parameter int REPEAT_CYCLES = REPEAT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic activar,
   input  logic repetir_en,
   output logic pulso,
   output logic sostenido,
   output logic soltar
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

   estado_t          state_q;
   logic [CNT_W-1:0] count_q;
   logic             pulso_q;
   logic             sostenido_q;
   logic             soltar_q;
   logic             sube;
   logic             baja;

   detector_flanco u_flanco (
      .clk     (clk),
      .reset   (reset),
      .senal_i (activar),
      .sube_o  (sube),
      .baja_o  (baja)
   );

   // Inside WAIT/REPEAT the level was already high, so a falling edge is
   // exactly "button released"; release is tested first so it beats a
   // terminal count landing in the same cycle.

   // Sequencing FSM with shared hold/repeat counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pulso_q     <= 1'b0;
         sostenido_q <= 1'b0;
         soltar_q    <= 1'b0;
      end else begin
         pulso_q  <= 1'b0;
         soltar_q <= 1'b0;
         case (state_q)
            IDLE: begin
               sostenido_q <= 1'b0;
               count_q     <= '0;
               if (sube) begin
                  pulso_q <= 1'b1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               sostenido_q <= 1'b0;
               if (baja) begin
                  state_q  <= IDLE;
                  soltar_q <= 1'b1;
                  count_q  <= '0;
               end else if (count_q == HOLD_TC) begin
                  // hold expired: fire now, or sit saturated until repeat is allowed
                  if (repetir_en) begin
                     pulso_q     <= 1'b1;
                     sostenido_q <= 1'b1;
                     count_q     <= '0;
                     state_q     <= REPEAT;
                  end
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (baja) begin
                  state_q     <= IDLE;
                  sostenido_q <= 1'b0;
                  soltar_q    <= 1'b1;
                  count_q     <= '0;
               end else if (!repetir_en) begin
                  // park in WAIT with the delay already expired so re-enabling
                  // resumes repeating without a fresh hold delay
                  state_q     <= WAIT;
                  count_q     <= HOLD_TC;
                  sostenido_q <= 1'b0;
               end else if (count_q == REP_TC) begin
                  pulso_q <= 1'b1;
                  count_q <= '0;
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end
            default: begin
               state_q     <= IDLE;
               count_q     <= '0;
               sostenido_q <= 1'b0;
            end
         endcase
      end
   end

   assign pulso     = pulso_q;
   assign sostenido = sostenido_q;
   assign soltar    = soltar_q;

endmodule

// File: tb/tb_boton_pulso_repeticion.sv
// Bench for boton_pulso_repeticion with HOLD_CYCLES=8, REPEAT_CYCLES=4.
// Reference model works in timestamps: time of the last pulse and a phase.
module tb_boton_pulso_repeticion;

   localparam int H = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic activar = 1'b0;
   logic repetir_en = 1'b1;
   logic pulso, sostenido, soltar;

   boton_pulso_repeticion #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk        (clk),
      .reset      (reset),
      .activar    (activar),
      .repetir_en (repetir_en),
      .pulso      (pulso),
      .sostenido  (sostenido),
      .soltar     (soltar)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // model: phase 0 = released, 1 = holding before repeat, 2 = repeating
   int phase = 0;
   int tref = 0;
   bit m_prev = 1'b1;
   bit exp_p = 1'b0, exp_so = 1'b0, exp_sl = 1'b0;
   bit last_pulso = 1'b0;
   int pulse_q[$];
   bit saw_sost;

   typedef struct {
      bit act; bit en; bit rst;
      bit p;   bit so; bit sl;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge(input bit a, input bit en, input bit rst);
      exp_p  = 1'b0;
      exp_sl = 1'b0;
      if (rst) begin
         phase  = 0;
         m_prev = 1'b1;
         exp_so = 1'b0;
         return;
      end
      case (phase)
         0: if (a && !m_prev) begin exp_p = 1'b1; phase = 1; tref = cyc; end
         1: begin
            if (!a) begin exp_sl = 1'b1; phase = 0; end
            else if (en && (cyc - tref >= H)) begin exp_p = 1'b1; phase = 2; tref = cyc; end
         end
         default: begin
            if (!a) begin exp_sl = 1'b1; phase = 0; end
            else if (!en) begin phase = 1; tref = cyc - H; end
            else if (cyc - tref >= R) begin exp_p = 1'b1; tref = cyc; end
         end
      endcase
      exp_so = (phase == 2);
      m_prev = a;
   endtask

   task automatic step(input bit a, input bit en, input bit rst);
      @(negedge clk);
      activar    = a;
      repetir_en = en;
      reset      = rst;
      @(posedge clk);
      cyc++;
      model_edge(a, en, rst);
      #1;
      if (pulso === 1'b1) pulse_q.push_back(cyc);
      if (sostenido === 1'b1) saw_sost = 1'b1;
   endtask

   task automatic check_model();
      chk("pulso", pulso, exp_p);
      chk("sostenido", sostenido, exp_so);
      chk("soltar", soltar, exp_sl);
   endtask

   initial begin
      int k;
      int offs[4];
      bit a_r, en_r, rst_r;
      offs = '{0, 8, 12, 16};

      tbl[0]  = '{1,1,0, 1,0,0};
      tbl[1]  = '{1,1,0, 0,0,0};
      tbl[2]  = '{1,1,0, 0,0,0};
      tbl[3]  = '{0,1,0, 0,0,1};
      tbl[4]  = '{0,1,0, 0,0,0};
      tbl[5]  = '{1,1,0, 1,0,0};
      tbl[6]  = '{1,1,1, 0,0,0};
      tbl[7]  = '{1,1,1, 0,0,0};
      tbl[8]  = '{1,1,0, 0,0,0};
      tbl[9]  = '{1,1,0, 0,0,0};
      tbl[10] = '{0,1,0, 0,0,0};
      tbl[11] = '{1,1,0, 1,0,0};
      tbl[12] = '{0,1,0, 0,0,1};
      tbl[13] = '{0,1,0, 0,0,0};

      // reset state
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("rst_pulso", pulso, 1'b0);
      chk("rst_sostenido", sostenido, 1'b0);
      chk("rst_soltar", soltar, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_model();

      // short press and button held through reset
      foreach (tbl[i]) begin
         step(tbl[i].act, tbl[i].en, tbl[i].rst);
         chk("tbl_pulso", pulso, tbl[i].p);
         chk("tbl_sostenido", sostenido, tbl[i].so);
         chk("tbl_soltar", soltar, tbl[i].sl);
         check_model();
      end

      // long hold with repeat enabled
      pulse_q.delete();
      k = cyc + 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check_model();
         if (i == 7) chk("long_sost_before", sostenido, 1'b0);
         if (i == 8) chk("long_sost_on", sostenido, 1'b1);
         if (i == 19) chk("long_sost_held", sostenido, 1'b1);
      end
      step(1'b0, 1'b1, 1'b0);
      check_model();
      chk("long_soltar", soltar, 1'b1);
      chk("long_release_pulso", pulso, 1'b0);
      chk("long_sost_off", sostenido, 1'b0);
      chk_int("long_npulses", pulse_q.size(), 4);
      for (int j = 0; j < 4; j++)
         if (j < pulse_q.size()) chk_int("long_pulse_time", pulse_q[j] - k, offs[j]);

      // long hold with repeat disabled
      step(1'b0, 1'b0, 1'b0);
      pulse_q.delete();
      saw_sost = 1'b0;
      k = cyc + 1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check_model();
      end
      step(1'b0, 1'b0, 1'b0);
      check_model();
      chk("norep_soltar", soltar, 1'b1);
      chk("norep_saw_sost", saw_sost, 1'b0);
      chk_int("norep_npulses", pulse_q.size(), 1);
      if (pulse_q.size() > 0) chk_int("norep_pulse_time", pulse_q[0] - k, 0);

      // release lands on the hold terminal count
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check_model();
      end
      step(1'b0, 1'b1, 1'b0);
      check_model();
      chk("tc_release_pulso", pulso, 1'b0);
      chk("tc_release_soltar", soltar, 1'b1);

      // reset while repeating, button stays held
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check_model();
      end
      chk("rep_before_reset", sostenido, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("rep_rst_pulso", pulso, 1'b0);
      chk("rep_rst_sostenido", sostenido, 1'b0);
      chk("rep_rst_soltar", soltar, 1'b0);
      pulse_q.delete();
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check_model();
      end
      chk_int("rep_rst_npulses", pulse_q.size(), 0);
      step(1'b0, 1'b1, 1'b0);
      chk("rep_rst_no_soltar", soltar, 1'b0);

      // randomized activity against the model
      a_r = 1'b0;
      en_r = 1'b1;
      last_pulso = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) a_r = ~a_r;
         if ($urandom_range(0, 24) == 0) en_r = ~en_r;
         rst_r = ($urandom_range(0, 299) == 0);
         step(a_r, en_r, rst_r);
         check_model();
         chk("pulso_and_soltar", pulso & soltar, 1'b0);
         chk("pulso_twice", pulso & last_pulso, 1'b0);
         last_pulso = pulso;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boton_pulso_repeticion.md
Name: boton_pulso_repeticion

Overview:
- Downstream stage of the button debouncer: consumes its debounced level `activar` and turns it into single-cycle command pulses for the time-setting logic.
- Press: one pulse immediately.
- Sustained hold: after a hold delay, pulses repeat at a fixed period (auto-increment while the button is held).
- Also reports a "held" flag and a one-cycle release pulse.

Parameters:
- HOLD_CYCLES, 50_000_000, clk cycles from the first pulse to the first repeat pulse; must be >= 2.
- REPEAT_CYCLES, 10_000_000, clk cycles between consecutive repeat pulses; must be >= 2.
- CNT_W, $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)), derived width of the shared counter; not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- activar  input  1  debounced button level, already synchronous to clk.
- repetir_en  input  1  1 = auto-repeat allowed; 0 = single pulse per press only.
- pulso  output  1  one-cycle command pulse (press or repeat).
- sostenido  output  1  high while in auto-repeat.
- soltar  output  1  one-cycle pulse on release after a press.

Behaviour:
- All outputs are registered. Reset values: pulso=0, sostenido=0, soltar=0, state=IDLE, count=0, prev=1.
- prev resets to 1, so a button held through reset emits nothing until it is released and pressed again.
- prev <= activar every cycle. A rising edge is activar=1 && prev=0.
- States: IDLE, WAIT, REPEAT.
- IDLE:
  - On a rising edge at edge k: pulso=1 for that cycle (visible after edge k), count<=0, go to WAIT.
  - Otherwise stay; all outputs 0.
- WAIT:
  - activar=0: go to IDLE, soltar<=1 for one cycle, count<=0.
  - Else if count==HOLD_CYCLES-1 and repetir_en=1: pulso<=1, sostenido<=1, count<=0, go to REPEAT.
  - Else if count==HOLD_CYCLES-1 and repetir_en=0: stay in WAIT, count saturates, no pulses.
  - Else count<=count+1.
- REPEAT:
  - activar=0: go to IDLE, sostenido<=0, soltar<=1, count<=0.
  - Else if repetir_en=0: go to WAIT with count saturated at HOLD_CYCLES-1; sostenido<=0; no pulse that cycle.
  - Else if count==REPEAT_CYCLES-1: pulso<=1, count<=0.
  - Else count<=count+1.
- Timing from press edge k, with activar held: pulses at edges k, k+HOLD_CYCLES, then k+HOLD_CYCLES+n*REPEAT_CYCLES.
- Release in the same cycle as a terminal count: release wins. soltar=1, pulso=0.
- Rising edge while in WAIT/REPEAT: impossible, since activar was already 1.
- pulso and soltar are never high in the same cycle. pulso is never high for two consecutive cycles.
- Reset mid-operation takes priority over everything: state IDLE, outputs 0 in the next cycle, no soltar is emitted.
- Counter width is CNT_W, unsigned. Compares are exact equality. No wrap is possible because the counter is cleared at terminal count.

Decomposition:
- Shared package (boton_pkg):
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, REPEAT=2'd2.
  - Default timing constants HOLD_DEFAULT, REPEAT_DEFAULT for the 100 MHz board.
  - Width helper used for CNT_W.
- Natural sub-module: detector_flanco (registered rising/falling edge detector, prev reset to 1).
- The FSM and counter stay in boton_pulso_repeticion.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4 in bench):
- Short press: activar high 3 cycles from edge k -> pulso=1 at k only; soltar=1 at k+3; sostenido never 1.
- Long hold, repetir_en=1, activar high 20 cycles from k -> pulso at k, k+8, k+12, k+16; sostenido=1 from k+8 until the release edge k+20; soltar at k+20; exactly 4 pulses.
- repetir_en=0, activar held 20 cycles -> single pulso at k; sostenido stays 0; soltar at release.
- Release coinciding with terminal count (activar falls so that edge k+8 samples 0) -> no pulso at k+8; soltar=1 at k+8.
- Button held through reset: activar=1 before, during and after reset -> no pulso; after release and re-press at edge m, pulso at m.
- Reset asserted during REPEAT -> next cycle pulso=0, sostenido=0, soltar=0, state IDLE; no pulses while activar stays 1.
